// File: rtl/hw2_addmul_arbiter.sv
// hw2_addmul_arbiter
//
// Shares a single registered (a +/- b) * c unit among NREQ requesters.
// Each requester presents operands on a valid/ready channel. Results are
// returned on one response channel and tagged with the requester index.
// Arbitration happens only while the unit is idle. A transaction walks
// IDLE -> EXEC -> RESP, so at most one result is ever in flight.
//
// Optional build macro: HW2_ARB_FIXED_PRIO_EN
//   undefined (default): round-robin. The search starts one past the
//                        requester served last.
//   defined            : fixed priority, lowest requester index wins.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept, one-hot or zero, only in IDLE
//   req_a/b/c    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_s        per-requester op select, 1 = add, 0 = subtract
//   resp_valid   result available, held until resp_ready
//   resp_ready   consumer accepts result
//   resp_d       2*WIDTH-bit result
//   resp_id      index of the requester that produced resp_d
//   busy         high whenever the FSM is not in IDLE

module hw2_addmul_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_c,
    input  logic [NREQ-1:0]       req_s,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [2*WIDTH-1:0]    resp_d,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   op_c;
    logic               op_s;
    logic [IDW-1:0]     op_id;
`ifndef HW2_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     rr_ptr;
`endif

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   sel_c;
    logic               sel_s;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] ext_c;
    logic [2*WIDTH-1:0] sum_diff;
    logic [2*WIDTH-1:0] product;

    // Grant search: step k visits requester (start + k) mod NREQ. The first
    // valid one wins. The inner loop compares against the requester index
    // rather than indexing with a computed value, so every select is static.
    always_comb begin
        int start;
        start       = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
`ifndef HW2_ARB_FIXED_PRIO_EN
        start = int'(rr_ptr);
`endif
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && req_valid[i] && (i == (start + k) % NREQ)) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(i);
                end
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        sel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_c = req_c[i*WIDTH +: WIDTH];
                sel_s = req_s[i];
            end
        end
    end

    // The accept is combinational, so a waiting requester sees it in the
    // same cycle. It is only ever asserted from IDLE.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == IDLE) && grant_found && (grant_idx == IDW'(i));
        end
    end

    // Arithmetic runs in 2*WIDTH context on zero-extended operands. A
    // subtraction with a < b therefore wraps to its two's-complement value
    // before the multiply.
    assign ext_a    = {{WIDTH{1'b0}}, op_a};
    assign ext_b    = {{WIDTH{1'b0}}, op_b};
    assign ext_c    = {{WIDTH{1'b0}}, op_c};
    assign sum_diff = op_s ? (ext_a + ext_b) : (ext_a - ext_b);
    assign product  = sum_diff * ext_c;

    // Transaction sequencer. The result is computed from the latched operands
    // during the single EXEC cycle. It is then held in RESP for as long as
    // the consumer stalls. The round-robin pointer only advances once the
    // response has been taken, so a reset mid-flight leaves it at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= '0;
            op_s       <= 1'b0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_d     <= '0;
            resp_id    <= '0;
            busy       <= 1'b0;
`ifndef HW2_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_c  <= sel_c;
                        op_s  <= sel_s;
                        op_id <= grant_idx;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_d     <= product;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
`ifndef HW2_ARB_FIXED_PRIO_EN
                        rr_ptr     <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
`endif
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hw2_addmul_arbiter.sv
// tb_hw2_addmul_arbiter
//
// Directed bench for hw2_addmul_arbiter (WIDTH=8, NREQ=4, IDW=2). Inputs are
// driven 1 time unit after the rising edge. Outputs are sampled either in
// that same slot or 1 unit later after combinational settling.

module tb_hw2_addmul_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int NSWP  = 200;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*WIDTH-1:0] req_c;
    logic [NREQ-1:0]       req_s;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [2*WIDTH-1:0]    resp_d;
    logic [IDW-1:0]        resp_id;
    logic                  busy;

    int vectors    = 0;
    int miscompares = 0;

    hw2_addmul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_s      (req_s),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_d     (resp_d),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // (a +/- b) * c in 16-bit context with zero-extended operands
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic s);
        logic [15:0] t;
        t = s ? ({8'h00, a} + {8'h00, b}) : ({8'h00, a} - {8'h00, b});
        golden = t * {8'h00, c};
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic s);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_c[i*WIDTH +: WIDTH] = c;
        req_s[i]                = s;
        req_valid[i]            = 1'b1;
    endtask

    // Wait (bounded) for resp_valid. The caller is at post-edge +1.
    task automatic wait_resp(output bit ok);
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = resp_valid;
    endtask

    task automatic test_reset;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        req_s      = '0;
        resp_ready = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        vectors++; if (resp_d !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_resp_d: got %h expected 0000", resp_d); end
        vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add;
        resp_ready = 1'b1;
        set_req(0, 8'd200, 8'd100, 8'd200, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL add_grant: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL add_busy_exec: got %b expected 1", busy); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL add_ready_exec: got %b expected 0000", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_valid_exec: got %b expected 0", resp_valid); end
        @(posedge clk); #1;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_latency: got %b expected 1", resp_valid); end
        vectors++; if (resp_d !== 16'd60000) begin miscompares++; $display("[TB] FAIL add_data: got %0d expected 60000", resp_d); end
        vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL add_id: got %0d expected 0", resp_id); end
        @(posedge clk); #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_valid_drop: got %b expected 0", resp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL add_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_sub_wrap;
        bit ok;
        resp_ready = 1'b1;
        set_req(2, 8'd3, 8'd5, 8'd2, 1'b0);
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL wrap_grant: got %b expected 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL wrap_timeout: got no response expected one"); end
        vectors++; if (resp_d !== 16'hFFFC) begin miscompares++; $display("[TB] FAIL wrap_data: got %h expected fffc", resp_d); end
        vectors++; if (resp_id !== 2'd2) begin miscompares++; $display("[TB] FAIL wrap_id: got %0d expected 2", resp_id); end
        @(posedge clk); #1;
        set_req(2, 8'd255, 8'd0, 8'd255, 1'b0);
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL sub_grant: got %b expected 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL sub_timeout: got no response expected one"); end
        vectors++; if (resp_d !== 16'd65025) begin miscompares++; $display("[TB] FAIL sub_data: got %0d expected 65025", resp_d); end
        vectors++; if (resp_id !== 2'd2) begin miscompares++; $display("[TB] FAIL sub_id: got %0d expected 2", resp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        bit          ok;
        logic [15:0] exp_d [4];
        logic [1:0]  exp_id [5];
        exp_d[0] = 16'd91;
        exp_d[1] = 16'd120;
        exp_d[2] = 16'd65436;
        exp_d[3] = 16'd64514;
`ifdef HW2_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++) exp_id[k] = 2'd0;
`else
        for (int k = 0; k < 5; k++) exp_id[k] = 2'(k % 4);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        set_req(0, 8'd10, 8'd3, 8'd7, 1'b1);
        set_req(1, 8'd50, 8'd20, 8'd4, 1'b0);
        set_req(2, 8'd1, 8'd2, 8'd100, 1'b0);
        set_req(3, 8'd255, 8'd255, 8'd255, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_resp(ok);
            vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL rr_timeout[%0d]: got no response expected one", k); end
            vectors++; if (resp_id !== exp_id[k]) begin miscompares++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", k, resp_id, exp_id[k]); end
            vectors++; if (resp_d !== exp_d[exp_id[k]]) begin miscompares++; $display("[TB] FAIL rr_data[%0d]: got %0d expected %0d", k, resp_d, exp_d[exp_id[k]]); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure;
        bit ok;
        resp_ready = 1'b0;
        set_req(1, 8'd12, 8'd4, 8'd10, 1'b0);
        set_req(3, 8'd9, 8'd9, 8'd9, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL bp_grant: got %b expected 0010", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 5; n++) begin
            vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", n, resp_valid); end
            vectors++; if (resp_d !== 16'd80) begin miscompares++; $display("[TB] FAIL bp_data[%0d]: got %0d expected 80", n, resp_d); end
            vectors++; if (resp_id !== 2'd1) begin miscompares++; $display("[TB] FAIL bp_id[%0d]: got %0d expected 1", n, resp_id); end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", n, req_ready); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_busy[%0d]: got %b expected 1", n, busy); end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release: got %b expected 0", resp_valid); end
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL bp_next_grant: got %b expected 1000", req_ready); end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_resp(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL bp_next_timeout: got no response expected one"); end
        vectors++; if (resp_d !== 16'd162) begin miscompares++; $display("[TB] FAIL bp_next_data: got %0d expected 162", resp_d); end
        vectors++; if (resp_id !== 2'd3) begin miscompares++; $display("[TB] FAIL bp_next_id: got %0d expected 3", resp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        bit ok;
        resp_ready = 1'b1;
        set_req(1, 8'd7, 8'd1, 8'd1, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        vectors++; if (!ok || resp_id !== 2'd1 || resp_d !== 16'd8) begin miscompares++; $display("[TB] FAIL mid_prep: got ok=%b id=%0d d=%0d expected ok=1 id=1 d=8", ok, resp_id, resp_d); end
        @(posedge clk); #1;
        set_req(3, 8'd20, 8'd10, 8'd2, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_exec: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy_async: got %b expected 0", busy); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid_async: got %b expected 0", resp_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_no_resp[%0d]: got %b expected 0", n, resp_valid); end
        end
        set_req(0, 8'd100, 8'd1, 8'd3, 1'b0);
        set_req(2, 8'd5, 8'd5, 8'd5, 1'b1);
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_grant_from0: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_after_timeout: got no response expected one"); end
        vectors++; if (resp_d !== 16'd297) begin miscompares++; $display("[TB] FAIL mid_after_data: got %0d expected 297", resp_d); end
        vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_after_id: got %0d expected 0", resp_id); end
        @(posedge clk); #1;
    endtask

    function automatic int next_for(input int i, input int from, input int tr[NSWP]);
        next_for = NSWP;
        for (int k = NSWP - 1; k >= from; k--) begin
            if (tr[k] == i) next_for = k;
        end
    endfunction

    task automatic test_regression_sweep;
        logic [7:0]  ta [NSWP];
        logic [7:0]  tb [NSWP];
        logic [7:0]  tc [NSWP];
        logic        ts [NSWP];
        int          tr [NSWP];
        int          ptr [NREQ];
        int          cnt [NREQ];
        int          returned [NREQ];
        int          done;
        int          cyc;
        int          taken;
        bit          pending;
        logic [15:0] exp_d;
        int          exp_id;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]      = 0;
            returned[i] = 0;
        end
        for (int k = 0; k < NSWP; k++) begin
            ta[k] = 8'($urandom_range(0, 255));
            tb[k] = 8'($urandom_range(0, 255));
            tc[k] = 8'($urandom_range(0, 255));
            ts[k] = 1'($urandom_range(0, 1));
            tr[k] = int'($urandom_range(0, NREQ - 1));
            cnt[tr[k]]++;
        end
        for (int i = 0; i < NREQ; i++) ptr[i] = next_for(i, 0, tr);
        done    = 0;
        cyc     = 0;
        pending = 1'b0;
        exp_d   = '0;
        exp_id  = 0;
        while (done < NSWP && cyc < 6000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ptr[i] < NSWP) set_req(i, ta[ptr[i]], tb[ptr[i]], tc[ptr[i]], ts[ptr[i]]);
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            taken = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) taken = i;
            end
            if (taken >= 0) begin
                exp_d       = golden(ta[ptr[taken]], tb[ptr[taken]], tc[ptr[taken]], ts[ptr[taken]]);
                exp_id      = taken;
                pending     = 1'b1;
                ptr[taken]  = next_for(taken, ptr[taken] + 1, tr);
            end
            if (resp_valid && resp_ready) begin
                vectors++; if (!pending) begin miscompares++; $display("[TB] FAIL sweep_dup[%0d]: got unexpected response id %0d expected none", done, resp_id); end
                vectors++; if (int'(resp_id) != exp_id) begin miscompares++; $display("[TB] FAIL sweep_id[%0d]: got %0d expected %0d", done, resp_id, exp_id); end
                vectors++; if (resp_d !== exp_d) begin miscompares++; $display("[TB] FAIL sweep_data[%0d]: got %h expected %h", done, resp_d, exp_d); end
                returned[resp_id]++;
                pending = 1'b0;
                done++;
            end
            @(posedge clk); #1;
            cyc++;
            if (taken >= 0) req_valid[taken] = 1'b0;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        vectors++; if (done != NSWP) begin miscompares++; $display("[TB] FAIL sweep_count: got %0d responses expected %0d", done, NSWP); end
        for (int i = 0; i < NREQ; i++) begin
            vectors++; if (returned[i] != cnt[i]) begin miscompares++; $display("[TB] FAIL sweep_per_id[%0d]: got %0d expected %0d", i, returned[i], cnt[i]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_sub_wrap;
        test_round_robin;
        test_back_pressure;
        test_reset_mid_op;
        test_regression_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hw2_addmul_arbiter.md
Name: hw2_addmul_arbiter

Overview:
- Shares one registered (a ± b) * c arithmetic unit among NREQ independent requesters.
- Each requester uses a valid/ready request channel. A single response channel returns the result tagged with the requester ID.
- Grants are round-robin, so every requester is guaranteed service.
- Sits between the stimulus/command sources and the existing non-pipelined add/sub-multiply datapath, and owns its sequencing.

Parameters:
- WIDTH, 8, operand width of a, b, c; result width is 2*WIDTH.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  packed operand a; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand b; same packing.
- req_c  in  NREQ*WIDTH  packed operand c; same packing.
- req_s  in  NREQ  op select: 1 = add, 0 = subtract.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_d  out  2*WIDTH  result.
- resp_id  out  IDW  index of the requester that produced resp_d.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_d=0, resp_id=0, busy=0, operand registers=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On handshake: latch a, b, c, s and the grant ID into operand registers, then go to EXEC.
- EXEC (exactly 1 cycle):
  - resp_d <= result; resp_id <= latched ID; resp_valid <= 1; go to RESP.
  - req_ready=0.
- RESP:
  - Hold resp_d, resp_id and resp_valid stable while resp_ready=0; no stall limit.
  - On resp_valid & resp_ready: resp_valid <= 0; rr_ptr <= (latched ID + 1) mod NREQ; go to IDLE.
  - req_ready=0 throughout RESP.
- Latency: handshake at edge T gives resp_valid high after edge T+1 (visible in cycle T+1 → T+2).
- Throughput: at most one transaction every 3 cycles when resp_ready is held at 1.
- Arithmetic:
  - a, b, c are zero-extended to 2*WIDTH.
  - sum/difference is taken modulo 2**(2*WIDTH); product is taken modulo 2**(2*WIDTH).
  - Subtract with a<b therefore yields the two's-complement wrap, e.g. (3-5)*2 = 0xFFFC.
- Requester rule: once req_valid[i] is raised, operands must stay stable until req_ready[i]. The block does not check this.
- Dropping req_valid before grant is legal; the requester is then simply skipped.
- New requests arriving during EXEC/RESP wait; arbitration happens only in IDLE.
- Reset asserted mid-operation: the in-flight transaction is discarded, no response is produced, and rr_ptr returns to 0.

Optional Feature:
- Macro: HW2_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not used and its update is removed.
- Undefined (default): round-robin as described in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Single add: req0 a=200 b=100 c=200 s=1, resp_ready=1 → req_ready[0] the same cycle, resp_valid 2 edges later, resp_d=60000, resp_id=0, then back to IDLE.
- Subtract wrap: req2 a=3 b=5 c=2 s=0 → resp_d=16'hFFFC (65532), resp_id=2. Also a=255 b=0 c=255 s=0 → 65025.
- Round-robin fairness: all 4 req_valid held high with distinct operands → resp_id order 0,1,2,3,0, and each resp_d matches its requester's (a±b)*c. With HW2_ARB_FIXED_PRIO_EN → order 0,0,0,...
- Back-pressure: resp_ready=0 for 5 cycles after resp_valid → resp_d/resp_id stable, req_ready stays 0, busy=1. Raising resp_ready completes the transaction, and the next grant appears the cycle after.
- Reset mid-operation: assert rst during EXEC → resp_valid=0 immediately (async), no response emitted after release, the next grant starts from requester 0.
- Regression sweep: 200 random (a,b,c,s) tuples spread over random requesters, random resp_ready stalls → every response matches the 16-bit-context golden (a±b)*c, with no lost or duplicated IDs.
